// File: rtl/mod_power_sched.sv
// mod_power_sched: round-robin arbiter that shares one mod_power engine
// between N_REQ requesters. Each job latches its operands, pulses the engine
// reset for one cycle, waits for res_done and returns the tagged result.
// Optional RUN watchdog: define MOD_POWER_SCHED_TIMEOUT_EN.
module mod_power_sched #(
    parameter int WIDTH          = 512,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 4_000_000
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_number,
    input  logic [N_REQ*WIDTH-1:0]     req_exponent,
    input  logic [N_REQ*WIDTH-1:0]     req_modules,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       eng_aresetn,
    output logic [WIDTH-1:0]           eng_number,
    output logic [WIDTH-1:0]           eng_exponent,
    output logic [WIDTH-1:0]           eng_modules,
    input  logic [WIDTH-1:0]           eng_response,
    input  logic                       eng_res_done
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic [WIDTH-1:0] sel_number, sel_exponent, sel_modules;
    logic             sel_mod_zero;
    logic             tmo_hit;
    logic             parked;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin : grant_search
        logic [IDW:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign sel_number   = req_number  [int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_exponent = req_exponent[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_modules  = req_modules [int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_mod_zero = (sel_modules == '0);

`ifdef MOD_POWER_SCHED_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Watchdog: cleared when a job is granted, counts every RUN cycle.
    always_ff @(posedge aclk) begin
        if (areset)
            tmo_cnt <= '0;
        else if (state == S_IDLE && grant_found)
            tmo_cnt <= '0;
        else if (state == S_RUN)
            tmo_cnt <= tmo_cnt + 32'd1;
    end

    // res_done in the limit cycle has priority over the timeout.
    assign tmo_hit = (state == S_RUN) && !eng_res_done &&
                     (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
`endif

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
                    state_nxt = sel_mod_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_RUN;
            S_RUN: begin
                if (eng_res_done || tmo_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, result registers and round-robin pointer.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr       <= '0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            eng_number   <= '0;
            eng_exponent <= '0;
            eng_modules  <= '0;
            parked       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        eng_number   <= sel_number;
                        eng_exponent <= sel_exponent;
                        eng_modules  <= sel_modules;
                        rsp_id       <= grant_idx;
                        rr_ptr       <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        parked       <= 1'b0;
                        if (sel_mod_zero) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (eng_res_done) begin
                        rsp_data <= eng_response;
                        rsp_err  <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        parked   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Engine restarts in LOAD; stays parked in DONE after a timeout.
    assign eng_aresetn = ~areset & (state != S_LOAD) & ~(parked & (state == S_DONE));

endmodule

// File: tb/tb_mod_power_sched.sv
// Bench for mod_power_sched with a behavioural fixed-latency engine.
module tb_mod_power_sched;
    localparam int W = 16;
    localparam int L = 20;

    logic          clk = 1'b0;
    logic          areset;
    logic [1:0]    req_valid, req_ready;
    logic [2*W-1:0] req_number, req_exponent, req_modules;
    logic          rsp_valid, rsp_ready;
    logic [0:0]    rsp_id;
    logic [W-1:0]  rsp_data;
    logic          rsp_err, busy, eng_aresetn;
    logic [W-1:0]  eng_number, eng_exponent, eng_modules, eng_response;
    logic          eng_res_done;

    logic          spur = 1'b0;
    logic          eng_hang = 1'b0;
    int            eng_cnt = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    mod_power_sched #(.WIDTH(W), .N_REQ(2), .TIMEOUT_CYCLES(50)) dut (
        .aclk(clk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_number(req_number), .req_exponent(req_exponent), .req_modules(req_modules),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .eng_aresetn(eng_aresetn), .eng_number(eng_number), .eng_exponent(eng_exponent),
        .eng_modules(eng_modules), .eng_response(eng_response), .eng_res_done(eng_res_done)
    );

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [31:0] r, x, mm;
        if (m == '0) return '0;
        mm = {16'b0, m};
        r  = 32'd1 % mm;
        x  = {16'b0, b} % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[W-1:0];
    endfunction

    // Behavioural engine: done L cycles after leaving reset, held until next reset.
    always @(posedge clk) begin
        if (!eng_aresetn)   eng_cnt <= 0;
        else if (eng_cnt < L) eng_cnt <= eng_cnt + 1;
    end
    assign eng_res_done = (!eng_hang && eng_cnt == L) || spur;
    assign eng_response = spur ? 16'hDEAD : modexp(eng_number, eng_exponent, eng_modules);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   valid;
        logic [W-1:0] n0, e0, m0, n1, e1, m1;
        logic [1:0]   exp_ready;
        logic         exp_id;
        logic [W-1:0] exp_data;
        logic         exp_err;
        int           exp_lat;
        int           exp_eng_rst;
    } vec_t;

    // One complete job: drive, check grant, count cycles to rsp_valid, check result.
    task automatic do_job(input vec_t v, input string tag);
        int lat, rst_cyc, regrant;
        logic got;
        @(posedge clk); #1;
        req_valid    = v.valid;
        req_number   = {v.n1, v.n0};
        req_exponent = {v.e1, v.e0};
        req_modules  = {v.m1, v.m0};
        rsp_ready    = 1'b1;
        @(negedge clk);
        chk({tag, " grant"}, 64'(req_ready), 64'(v.exp_ready));
        lat = 0; rst_cyc = 0; regrant = 0; got = 1'b0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            lat++;
            if (!eng_aresetn) rst_cyc++;
            if (req_ready != 2'b00) regrant++;
            if (rsp_valid) got = 1'b1;
        end
        chk({tag, " rsp_seen"}, 64'(got), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, " eng_rst_cycles"}, 64'(rst_cyc), 64'(v.exp_eng_rst));
        chk({tag, " no_regrant"}, 64'(regrant), 64'd0);
        chk({tag, " id"}, 64'(rsp_id), 64'(v.exp_id));
        chk({tag, " data"}, 64'(rsp_data), 64'(v.exp_data));
        chk({tag, " err"}, 64'(rsp_err), 64'(v.exp_err));
    endtask

    vec_t vecs[11];

    initial begin
        int n, bad;
        vec_t tv;
        for (int i = 0; i < 6; i++) begin
            vecs[i] = '{2'b11, 16'd16, 16'd22, 16'd11, 16'd17, 16'd24, 16'd13,
                        (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 1),
                        (i % 2 == 0) ? 16'd3 : 16'd1, 1'b0, L + 3, 1};
        end
        vecs[6]  = '{2'b10, 16'd0, 16'd0, 16'd0, 16'd5, 16'd3, 16'd0,
                     2'b10, 1'b1, 16'd0, 1'b1, 1, 0};
        vecs[7]  = '{2'b01, 16'd16, 16'd22, 16'd11, 16'd0, 16'd0, 16'd0,
                     2'b01, 1'b0, 16'd3, 1'b0, L + 3, 1};
        vecs[8]  = '{2'b01, 16'd16, 16'd22, 16'd11, 16'd0, 16'd0, 16'd0,
                     2'b01, 1'b0, 16'd3, 1'b0, L + 3, 1};
        vecs[9]  = '{2'b10, 16'd0, 16'd0, 16'd0, 16'd3, 16'd5, 16'd7,
                     2'b10, 1'b1, 16'd5, 1'b0, L + 3, 1};
        vecs[10] = '{2'b01, 16'd2, 16'd10, 16'd1000, 16'd0, 16'd0, 16'd0,
                     2'b01, 1'b0, 16'd24, 1'b0, L + 3, 1};

        areset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_number = '0; req_exponent = '0; req_modules = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset eng_aresetn", 64'(eng_aresetn), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp", 64'({rsp_id, rsp_err, rsp_data}), 64'd0);
        chk("reset eng_ops", 64'({eng_number, eng_exponent, eng_modules}), 64'd0);
        @(posedge clk); #1 areset = 1'b0;

        for (int i = 0; i < 11; i++) do_job(vecs[i], $sformatf("vec%0d", i));

        // Backpressure in DONE: result stable, nothing granted.
        @(posedge clk); #1;
        req_valid = 2'b01; req_number = {16'd0, 16'd16}; req_exponent = {16'd0, 16'd22};
        req_modules = {16'd13, 16'd11}; rsp_ready = 1'b0;
        n = 0;
        while (n < 100 && !rsp_valid) begin @(negedge clk); n++; end
        chk("bp rsp_seen", 64'(rsp_valid), 64'd1);
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d", i), 64'({rsp_valid, rsp_id, rsp_err, rsp_data, req_ready}),
                64'({1'b1, 1'b0, 1'b0, 16'd3, 2'b00}));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp handshake no grant", 64'({rsp_valid, req_ready}), 64'({1'b1, 2'b00}));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp next grant", 64'({busy, req_ready}), 64'({1'b0, 2'b10}));
        req_valid = 2'b00;

        // Spurious res_done in IDLE and LOAD.
        @(posedge clk); #1 spur = 1'b1;
        @(negedge clk);
        chk("spur idle", 64'({rsp_valid, busy}), 64'd0);
        @(posedge clk); #1;
        spur = 1'b0; req_valid = 2'b10;
        req_number = {16'd17, 16'd0}; req_exponent = {16'd24, 16'd0}; req_modules = {16'd13, 16'd0};
        @(posedge clk); #1 spur = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        chk("spur load eng_aresetn", 64'(eng_aresetn), 64'd0);
        @(posedge clk); #1 spur = 1'b0;
        n = 2;
        while (n < 200) begin @(negedge clk); if (rsp_valid) break; n++; end
        chk("spur latency", 64'(n), 64'(L + 3));
        chk("spur result", 64'({rsp_id, rsp_err, rsp_data}), 64'({1'b1, 1'b0, 16'd1}));

        // areset mid-RUN.
        @(posedge clk); #1;
        req_valid = 2'b01; req_number = {16'd0, 16'd16}; req_exponent = {16'd0, 16'd22};
        req_modules = {16'd0, 16'd11};
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1 areset = 1'b1;
        @(negedge clk);
        chk("rst eng_aresetn", 64'(eng_aresetn), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst state", 64'({busy, rsp_valid, eng_aresetn, rsp_data}), 64'd0);
        @(posedge clk); #1 areset = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (rsp_valid) bad++; end
        chk("rst dropped job", 64'(bad), 64'd0);
        do_job(vecs[0], "post_rst");

`ifdef MOD_POWER_SCHED_TIMEOUT_EN
        eng_hang = 1'b1;
        tv = vecs[7];
        tv.exp_data = 16'd0; tv.exp_err = 1'b1; tv.exp_lat = 52; tv.exp_eng_rst = 2;
        tv.exp_ready = 2'b10; tv.valid = 2'b10;
        tv.n1 = 16'd16; tv.e1 = 16'd22; tv.m1 = 16'd11; tv.exp_id = 1'b1;
        do_job(tv, "timeout");
        eng_hang = 1'b0;
`else
        tv = vecs[7];
        do_job(tv, "final");
`endif
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
